// File: rtl/falu_result_collector_if.sv
// rtl/falu_result_collector_if.sv - issue, unit-return and writeback bundle for the FALU result collector
interface falu_result_collector_if #(
    parameter int XLEN   = 32,
    parameter int NUNITS = 5
);
    logic                   issue_valid;
    logic [2:0]             issue_sel;
    logic [4:0]             issue_rd;
    logic                   issue_ready;

    logic [NUNITS-1:0]      unit_done;
    logic [NUNITS*XLEN-1:0] unit_result;
    logic [NUNITS*5-1:0]    unit_fflags;
    logic [NUNITS-1:0]      unit_hold;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic [4:0]             wb_fflags;

    logic                   err_illegal;
    logic                   err_overflow;

    // Issue stage, FP units and writeback sink seen from outside the collector
    modport master (
        output issue_valid, issue_sel, issue_rd,
        output unit_done, unit_result, unit_fflags,
        output wb_ready,
        input  issue_ready, unit_hold,
        input  wb_valid, wb_rd, wb_data, wb_fflags,
        input  err_illegal, err_overflow
    );

    // The collector itself
    modport slave (
        input  issue_valid, issue_sel, issue_rd,
        input  unit_done, unit_result, unit_fflags,
        input  wb_ready,
        output issue_ready, unit_hold,
        output wb_valid, wb_rd, wb_data, wb_fflags,
        output err_illegal, err_overflow
    );
endinterface

// File: rtl/falu_result_collector.sv
// rtl/falu_result_collector.sv - in-order retirement of out-of-order FP unit results
module falu_result_collector #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int NUNITS = 5
) (
    input logic                    CLK,
    input logic                    rst,
    falu_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] MAX_SEL = 3'(NUNITS - 1);

    // Pending-op queue: program order of issued ops
    logic [2:0]  q_sel [DEPTH];
    logic [4:0]  q_rd  [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        legal;
    logic        push;

    // Per-unit hold registers for completed results
    logic [NUNITS-1:0] hold_valid;
    logic [XLEN-1:0]   hold_data  [NUNITS];
    logic [4:0]        hold_flags [NUNITS];

    // Head-of-queue view and retire decision
    logic [2:0]        head_sel;
    logic [4:0]        head_rd;
    logic [NUNITS-1:0] head_onehot;
    logic [XLEN-1:0]   head_data;
    logic [4:0]        head_flags;
    logic              head_done;
    logic              load;
    logic [NUNITS-1:0] drain;

    // Writeback and error registers
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [4:0]      wb_fflags_q;
    logic            err_illegal_q;
    logic            err_overflow_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign legal = (bus.issue_sel <= MAX_SEL);
    assign push  = bus.issue_valid && !full && legal;

    assign head_sel = q_sel[rd_ptr[AW-1:0]];
    assign head_rd  = q_rd[rd_ptr[AW-1:0]];

    // Decode the head's unit code and select that unit's held result
    always_comb begin
        head_onehot = '0;
        head_data   = '0;
        head_flags  = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (head_sel == 3'(i)) begin
                head_onehot[i] = 1'b1;
                head_data      = hold_data[i];
                head_flags     = hold_flags[i];
            end
        end
    end

    // Retire only when the oldest op has its result and the wb register is free
    assign head_done = |(head_onehot & hold_valid);
    assign load      = !empty && head_done && (!wb_valid_q || bus.wb_ready);
    assign drain     = load ? head_onehot : '0;

    // Ready is a pure function of registered occupancy, no retire bypass
    assign bus.issue_ready  = !full;
    assign bus.unit_hold    = hold_valid & ~drain;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_fflags    = wb_fflags_q;
    assign bus.err_illegal  = err_illegal_q;
    assign bus.err_overflow = err_overflow_q;

    // Queue storage; contents are don't-care while outside the pointer window
    always_ff @(posedge CLK) begin
        if (push) begin
            q_sel[wr_ptr[AW-1:0]] <= bus.issue_sel;
            q_rd[wr_ptr[AW-1:0]]  <= bus.issue_rd;
        end
    end

    // Queue pointers and the one-cycle illegal-select pulse
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            err_illegal_q <= bus.issue_valid && !legal;
        end
    end

    // Capture unit completions; a done into an occupied, non-draining slot is dropped and flagged
    always_ff @(posedge CLK) begin
        if (rst) begin
            hold_valid     <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUNITS; i++) begin
                if (bus.unit_done[i]) begin
                    if (hold_valid[i] && !drain[i]) begin
                        err_overflow_q <= 1'b1;
                    end else begin
                        hold_valid[i] <= 1'b1;
                        hold_data[i]  <= bus.unit_result[i*XLEN +: XLEN];
                        hold_flags[i] <= bus.unit_fflags[i*5 +: 5];
                    end
                end else if (drain[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Writeback register: loads on retire, clears once the sink takes the beat
    always_ff @(posedge CLK) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_fflags_q <= '0;
        end else if (load) begin
            wb_valid_q  <= 1'b1;
            wb_rd_q     <= head_rd;
            wb_data_q   <= head_data;
            wb_fflags_q <= head_flags;
        end else if (wb_valid_q && bus.wb_ready) begin
            wb_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_falu_result_collector.sv
// tb/tb_falu_result_collector.sv - scoreboard bench for falu_result_collector
module tb_falu_result_collector;
    localparam int XLEN   = 32;
    localparam int NUNITS = 5;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [4:0]      fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   mon_n;

    falu_result_collector_if #(.XLEN(XLEN), .NUNITS(NUNITS)) bus ();

    falu_result_collector #(.XLEN(XLEN), .DEPTH(4), .NUNITS(NUNITS)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd,
                         input logic [XLEN-1:0] data, input logic [4:0] fl, input bit accept);
        exp_t e;
        step();
        bus.issue_valid = 1'b1;
        bus.issue_sel   = sel;
        bus.issue_rd    = rd;
        if (accept) begin
            e.rd = rd; e.data = data; e.fl = fl;
            sb.push_back(e);
        end
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic complete(input int u, input logic [XLEN-1:0] data, input logic [4:0] fl);
        step();
        bus.unit_done[u]              = 1'b1;
        bus.unit_result[u*XLEN +: XLEN] = data;
        bus.unit_fflags[u*5 +: 5]     = fl;
        step();
        bus.unit_done = '0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check(tag, sb.size(), 0);
    endtask

    // Retire monitor: every accepted writeback beat must match the oldest expected op
    always @(negedge clk) begin
        if (!rst && bus.wb_valid && bus.wb_ready) begin
            if (sb.size() == 0) begin
                mon_n = sb.size();
                check("wb_extra_beat", mon_n, 1);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rd", bus.wb_rd, mon_e.rd);
                check("wb_data", bus.wb_data, mon_e.data);
                check("wb_fflags", bus.wb_fflags, mon_e.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_sel   = '0;
        bus.issue_rd    = '0;
        bus.unit_done   = '0;
        bus.unit_result = '0;
        bus.unit_fflags = '0;
        bus.wb_ready    = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_issue_ready", bus.issue_ready, 1);
        check("rst_unit_hold", bus.unit_hold, 0);
        check("rst_wb_rd", bus.wb_rd, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_wb_fflags", bus.wb_fflags, 0);
        check("rst_err_illegal", bus.err_illegal, 0);
        check("rst_err_overflow", bus.err_overflow, 0);

        // Single ADD: latency and beat clear
        issue(3'd0, 5'd3, 32'h3F80_0000, 5'b00001, 1);
        complete(0, 32'h3F80_0000, 5'b00001);
        @(negedge clk);
        check("t1_wb_not_yet", bus.wb_valid, 0);
        @(negedge clk);
        check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_rd", bus.wb_rd, 3);
        @(negedge clk);
        check("t1_wb_cleared", bus.wb_valid, 0);
        wait_drain("t1_drain", 10);

        // Out-of-order completion, in-order retire
        issue(3'd2, 5'd1, 32'hAAAA_0001, 5'b00010, 1);
        issue(3'd0, 5'd2, 32'hBBBB_0002, 5'b00100, 1);
        complete(0, 32'hBBBB_0002, 5'b00100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_add_held", bus.unit_hold[0], 1);
            check("t2_no_wb", bus.wb_valid, 0);
        end
        complete(2, 32'hAAAA_0001, 5'b00010);
        @(negedge clk);
        check("t2_add_still_held", bus.unit_hold[0], 1);
        @(negedge clk);
        check("t2_first_rd", bus.wb_rd, 1);
        check("t2_first_valid", bus.wb_valid, 1);
        @(negedge clk);
        check("t2_second_rd", bus.wb_rd, 2);
        check("t2_second_valid", bus.wb_valid, 1);
        wait_drain("t2_drain", 10);

        // Full queue, ignored 5th issue, then wrap
        for (int i = 0; i < 4; i++)
            issue(3'(i), 5'(10 + i), 32'h1000_0000 + 32'(i), 5'(i + 1), 1);
        @(negedge clk);
        check("t3_full_ready", bus.issue_ready, 0);
        issue(3'd4, 5'd14, 32'h0, 5'b0, 0);
        @(negedge clk);
        check("t3_still_full", bus.issue_ready, 0);
        check("t3_no_illegal", bus.err_illegal, 0);
        for (int i = 3; i >= 0; i--)
            complete(i, 32'h1000_0000 + 32'(i), 5'(i + 1));
        wait_drain("t3_drain_a", 20);
        issue(3'd4, 5'd20, 32'h2000_0004, 5'b10000, 1);
        issue(3'd0, 5'd21, 32'h2000_0000, 5'b01000, 1);
        issue(3'd1, 5'd22, 32'h2000_0001, 5'b00100, 1);
        issue(3'd2, 5'd23, 32'h2000_0002, 5'b00010, 1);
        step();
        bus.unit_done = 5'b10111;
        bus.unit_result[4*XLEN +: XLEN] = 32'h2000_0004; bus.unit_fflags[4*5 +: 5] = 5'b10000;
        bus.unit_result[0*XLEN +: XLEN] = 32'h2000_0000; bus.unit_fflags[0*5 +: 5] = 5'b01000;
        bus.unit_result[1*XLEN +: XLEN] = 32'h2000_0001; bus.unit_fflags[1*5 +: 5] = 5'b00100;
        bus.unit_result[2*XLEN +: XLEN] = 32'h2000_0002; bus.unit_fflags[2*5 +: 5] = 5'b00010;
        step();
        bus.unit_done = '0;
        wait_drain("t3_drain_b", 20);
        @(negedge clk);
        check("t3_ready_after", bus.issue_ready, 1);

        // Backpressure
        step();
        bus.wb_ready = 1'b0;
        issue(3'd1, 5'd5, 32'hC0DE_0005, 5'b00011, 1);
        issue(3'd3, 5'd6, 32'hD00D_0006, 5'b00101, 1);
        step();
        bus.unit_done = 5'b01010;
        bus.unit_result[1*XLEN +: XLEN] = 32'hC0DE_0005; bus.unit_fflags[1*5 +: 5] = 5'b00011;
        bus.unit_result[3*XLEN +: XLEN] = 32'hD00D_0006; bus.unit_fflags[3*5 +: 5] = 5'b00101;
        step();
        bus.unit_done = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_bp_valid", bus.wb_valid, 1);
            check("t4_bp_rd", bus.wb_rd, 5);
            check("t4_bp_data", bus.wb_data, 32'hC0DE_0005);
            check("t4_bp_fflags", bus.wb_fflags, 5'b00011);
            check("t4_bp_hold3", bus.unit_hold[3], 1);
        end
        step();
        bus.wb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_b2b_valid", bus.wb_valid, 1);
        check("t4_b2b_rd", bus.wb_rd, 6);
        wait_drain("t4_drain", 10);

        // Illegal select leaves the queue untouched
        issue(3'b110, 5'd7, 32'h0, 5'b0, 0);
        @(negedge clk);
        check("t5_illegal_pulse", bus.err_illegal, 1);
        @(negedge clk);
        check("t5_illegal_clear", bus.err_illegal, 0);
        check("t5_ready", bus.issue_ready, 1);
        issue(3'd4, 5'd9, 32'h4444_0009, 5'b00001, 1);
        complete(4, 32'h4444_0009, 5'b00001);
        wait_drain("t5_after_illegal", 10);

        // Overflow: second done into a full hold slot is dropped
        complete(1, 32'hE111_0001, 5'b00001);
        complete(1, 32'hE222_0002, 5'b00010);
        @(negedge clk);
        check("t5_overflow", bus.err_overflow, 1);
        check("t5_hold1", bus.unit_hold[1], 1);
        issue(3'd1, 5'd8, 32'hE111_0001, 5'b00001, 1);
        wait_drain("t5_keep_first", 10);
        @(negedge clk);
        check("t5_overflow_sticky", bus.err_overflow, 1);

        // Reset mid-operation discards pending ops and held results
        issue(3'd0, 5'd16, 32'h0, 5'b0, 0);
        issue(3'd2, 5'd17, 32'h0, 5'b0, 0);
        issue(3'd3, 5'd18, 32'h0, 5'b0, 0);
        complete(1, 32'hF00F_0001, 5'b11111);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_wb_valid", bus.wb_valid, 0);
        check("t6_issue_ready", bus.issue_ready, 1);
        check("t6_unit_hold", bus.unit_hold, 0);
        check("t6_overflow_clr", bus.err_overflow, 0);
        complete(0, 32'h5555_5555, 5'b0);
        complete(2, 32'h6666_6666, 5'b0);
        for (int i = 0; i < 8; i++) @(negedge clk);
        issue(3'd1, 5'd19, 32'h7777_0019, 5'b01010, 1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("t6_no_stale", sb.size(), 1);
        complete(1, 32'h7777_0019, 5'b01010);
        wait_drain("t6_drain", 10);

        for (int i = 0; i < 4; i++) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/falu_result_collector.md
Name: falu_result_collector

Overview:
- Return-path counterpart of the FALU one-hot unit-select decoder.
- Records each issued FP op (unit select, destination register) in an in-order pending queue.
- Captures results and flags from the five FP units (ADD_SUB, MUL, DIV, CMP, CVT) as they complete, possibly out of order.
- Retires results to the FP register-file writeback port in program order, using a valid/ready handshake.

Parameters:
- XLEN, 32, result width per unit
- DEPTH, 4, pending-op queue entries (power of 2, at least 2)
- NUNITS, 5, number of FP units; bit i corresponds to unit select code i

Ports:
- CLK  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  op issued this cycle
- issue_sel  in  3  unit code (000 ADD_SUB, 001 MUL, 010 DIV, 011 CMP, 100 CVT)
- issue_rd  in  5  destination FP register
- issue_ready  out  1  queue can accept an op
- unit_done  in  NUNITS  per-unit completion pulse
- unit_result  in  NUNITS*XLEN  flattened results; unit i at [i*XLEN +: XLEN]
- unit_fflags  in  NUNITS*5  flattened NV/DZ/OF/UF/NX flags; unit i at [i*5 +: 5]
- unit_hold  out  NUNITS  per-unit stall: unit i must hold its result and not pulse done
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  writeback sink accepts the beat
- wb_rd  out  5  destination register
- wb_data  out  XLEN  result
- wb_fflags  out  5  exception flags
- err_illegal  out  1  one-cycle pulse when an illegal issue_sel is presented
- err_overflow  out  1  sticky until reset: a unit pulsed done while its hold register was full

Behaviour:
- Reset: queue empty, all hold_valid cleared, wb_valid=0, wb_rd=0, wb_data=0, wb_fflags=0, err_illegal=0, err_overflow=0. issue_ready=1 and unit_hold=0 in the cycle after reset.
- Reset asserted mid-operation discards all pending ops and held results. No writeback occurs for them.
- Issue queue:
  - Circular FIFO of {sel, rd} with log2(DEPTH)+1-bit pointers; wrap-around by pointer MSB.
  - issue_ready = !full. It depends on registered state only; there is no same-cycle retire bypass.
  - Push when issue_valid && issue_ready && sel<=100.
  - sel 101..111 with issue_valid: no push; err_illegal=1 next cycle.
  - issue_valid while full: ignored, no error.
- Hold registers, one per unit:
  - On unit_done[i], capture result/flags and set hold_valid[i] at the next edge.
  - unit_hold[i] = hold_valid[i] && !drain[i] (combinational).
  - If unit_done[i] arrives while hold_valid[i] && !drain[i]: keep the old value and set err_overflow.
  - If drain and done coincide, the new value is loaded and hold_valid stays 1.
- Retire:
  - Head entry is h = queue[rd_ptr].
  - load = !empty && hold_valid[h.sel] && (!wb_valid || wb_ready).
  - On load: drain[h.sel]=1, pop the queue, and register wb_rd=h.rd, wb_data/wb_fflags = hold[h.sel], wb_valid=1.
  - Else if wb_valid && wb_ready: wb_valid=0.
  - wb outputs hold stable while wb_valid && !wb_ready.
- Ordering: a completed younger op never writes back before an older op still pending, even if they use different units.
- Latency: unit_done at edge N → hold captured at N → wb_valid at edge N+1, provided the op is at the head and the wb register is free. Sustained throughput is one retire per cycle.
- Simultaneous push and pop in one cycle: both take effect; occupancy unchanged.
- Completion for a unit with no pending entry is captured and waits; no error is raised.

Test Plan:
- Reset, then issue ADD (sel 000, rd 3); unit_done[0] with data 0x3F800000 and flags 00001 two cycles later → wb_valid one cycle after done, wb_rd=3, wb_data=0x3F800000, wb_fflags=00001; wb_ready=1 → wb_valid=0 next cycle.
- Out-of-order completion: issue DIV (rd 1) then ADD (rd 2); ADD completes at t=3 and DIV at t=20 → unit_hold[0]=1 from t=4 until DIV retires; writeback order is rd1 then rd2 on consecutive cycles.
- Full/wrap: issue 4 ops with no completion → issue_ready=0 and a 5th issue is ignored. Complete all four, then issue 4 more → all 8 retire in order; pointers wrap correctly.
- Backpressure: wb_ready=0 for 5 cycles with wb_valid=1 → wb_rd/data/fflags unchanged. Next head result stays held with unit_hold asserted. Release wb_ready → back-to-back retirement.
- Illegal/overflow: issue_sel=110 → err_illegal pulses 1 cycle and the queue is unchanged. Pulse unit_done[1] twice with no drain → err_overflow=1 and stays 1 until rst; the first held value is retained.
- Reset mid-operation: 3 ops pending and 1 held result; rst for one cycle → wb_valid=0, issue_ready=1, no writeback of the old ops afterward.
